traffic_conflict_monitor: RTL and testbench

//  Watches the six lamp outputs of the traffic light controller and checks them against
//  the signalling rules: no conflicting greens, one-hot lamps, legal G->Y->R order,

---
 rtl/traffic_conflict_monitor.sv | 85 ++++++++
 tb/tb_traffic_conflict_monitor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: checks controller lamp outputs against signalling rules and latches the first violation
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 1,
  parameter int MIN_ALLRED = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flash,
  input  logic             NSG,
  input  logic             NSY,
  input  logic             NSR,
  input  logic             EWG,
  input  logic             EWY,
  input  logic             EWR,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_pulse,
  output logic             force_flash,
  output logic [CNT_W-1:0] cycles_done
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int AW = $clog2(MIN_ALLRED + 1);
  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
  localparam logic [5:0] ALL_RED = 6'b001001;
  logic [5:0] lamps, prev;
  logic [2:0] ns, ew, pns, pew, code;
  logic prev_valid, prev_fl;
  logic [YW-1:0] ycnt_ns, ycnt_ew;
  logic [AW-1:0] ar_cnt;
  logic conflict, bad_lamp, bad_seq, short_y, clr, bad_flash, ew_done;
  function automatic logic onehot(input logic [2:0] x);
    return x == G || x == Y || x == R;
  endfunction
  function automatic logic legal(input logic [2:0] p, input logic [2:0] c);
    return p == c || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
  endfunction
  assign lamps = {NSG, NSY, NSR, EWG, EWY, EWR};
  assign ns = lamps[5:3];
  assign ew = lamps[2:0];
  assign pns = prev[5:3];
  assign pew = prev[2:0];
  assign force_flash = fault;
  always_comb begin
    conflict  = (NSG | NSY) & (EWG | EWY);
    bad_lamp  = !onehot(ns) || !onehot(ew);
    bad_seq   = prev_valid && (!legal(pns, ns) || !legal(pew, ew));
    short_y   = prev_valid && ((pns == Y && ns == R && ycnt_ns < YW'(MIN_YELLOW)) ||
                               (pew == Y && ew == R && ycnt_ew < YW'(MIN_YELLOW)));
    clr       = ar_cnt < AW'(MIN_ALLRED) && ((ns == G && !(prev_valid && pns == G)) ||
                                             (ew == G && !(prev_valid && pew == G)));
    bad_flash = !(lamps == 6'b0 || lamps == ALL_RED) || (prev_fl && lamps == prev);
    ew_done   = !flash && prev_valid && pew == Y && ew == R;
    code      = conflict ? 3'd1 : flash ? (bad_flash ? 3'd6 : 3'd0) : bad_lamp ? 3'd2 :
                bad_seq ? 3'd3 : short_y ? 3'd4 : clr ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_pulse <= 1'b0;
      cycles_done <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      prev_fl     <= 1'b0;
      ycnt_ns     <= '0;
      ycnt_ew     <= '0;
      ar_cnt      <= AW'(MIN_ALLRED);
    end else begin
      prev        <= lamps;
      prev_valid  <= !flash;
      prev_fl     <= flash;
      ycnt_ns     <= ns != Y ? '0 : ycnt_ns == YW'(MIN_YELLOW) ? ycnt_ns : ycnt_ns + YW'(1);
      ycnt_ew     <= ew != Y ? '0 : ycnt_ew == YW'(MIN_YELLOW) ? ycnt_ew : ycnt_ew + YW'(1);
      // flash clears the all-red history so a green after flash needs fresh clearance
      ar_cnt      <= (flash || lamps != ALL_RED) ? '0 : ar_cnt == AW'(MIN_ALLRED) ? ar_cnt : ar_cnt + AW'(1);
      fault_pulse <= !fault && code != 3'd0;
      if (!fault && code != 3'd0) begin
        fault      <= 1'b1;
        fault_code <= code;
      end
      if (ew_done && cycles_done != '1) cycles_done <= cycles_done + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: randomized and directed checks of two monitor configurations against a history-based model
module tb_traffic_conflict_monitor;
  logic clk = 0, reset = 0, flash = 0;
  logic NSG = 0, NSY = 0, NSR = 1, EWG = 0, EWY = 0, EWR = 1;
  logic f1, p1, ff1, f2, p2, ff2;
  logic [2:0] c1, c2;
  logic [7:0] cy1;
  logic [2:0] cy2;
  int errors = 0, checks = 0;

  traffic_conflict_monitor u_dut1 (
    .clk(clk), .reset(reset), .flash(flash),
    .NSG(NSG), .NSY(NSY), .NSR(NSR), .EWG(EWG), .EWY(EWY), .EWR(EWR),
    .fault(f1), .fault_code(c1), .fault_pulse(p1), .force_flash(ff1), .cycles_done(cy1));
  traffic_conflict_monitor #(.MIN_YELLOW(2), .MIN_ALLRED(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .reset(reset), .flash(flash),
    .NSG(NSG), .NSY(NSY), .NSR(NSR), .EWG(EWG), .EWY(EWY), .EWR(EWR),
    .fault(f2), .fault_code(c2), .fault_pulse(p2), .force_flash(ff2), .cycles_done(cy2));

  always #5 clk = ~clk;

  typedef struct { logic [5:0] l; logic f; } smp_t;
  smp_t hist[$];
  int my[2] = '{1, 2};
  int ma[2] = '{1, 2};
  int cmax[2] = '{255, 7};
  bit mf[2], mp[2];
  logic [2:0] mc[2];
  int mcy[2];

  function automatic int pos(input logic [2:0] x);
    return x == 3'b100 ? 0 : x == 3'b010 ? 1 : x == 3'b001 ? 2 : -1;
  endfunction
  function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
    return p == c || (pos(p) >= 0 && pos(c) == (pos(p) + 1) % 3);
  endfunction
  function automatic int ones(input logic [2:0] x);
    return int'(x[0]) + int'(x[1]) + int'(x[2]);
  endfunction
  function automatic int ycnt(input bit ns_dir);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      logic [5:0] v;
      v = hist[i].l;
      if ((ns_dir ? v[5:3] : v[2:0]) != 3'b010) break;
      n++;
    end
    return n;
  endfunction
  // consecutive normal-mode all-red samples; an unbroken run back to reset counts as satisfied
  function automatic int arcnt(input int cap);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].f || hist[i].l != 6'b001001) return n;
      n++;
    end
    return cap;
  endfunction

  task automatic model_reset();
    hist.delete();
    mf = '{0, 0}; mp = '{0, 0}; mc = '{3'd0, 3'd0}; mcy = '{0, 0};
  endtask

  task automatic model_step(input logic [5:0] l, input logic f);
    bit pv, pf;
    logic [5:0] pl;
    smp_t s;
    pv = 0; pf = 0; pl = '0;
    if (hist.size() > 0) begin
      pl = hist[hist.size()-1].l;
      pf = hist[hist.size()-1].f;
      pv = !pf;
    end
    for (int k = 0; k < 2; k++) begin
      int c;
      c = 0;
      if ((l[5] | l[4]) && (l[2] | l[1])) c = 1;
      else if (f) c = (!(l == 6'b0 || l == 6'b001001) || (pf && pl == l)) ? 6 : 0;
      else if (ones(l[5:3]) != 1 || ones(l[2:0]) != 1) c = 2;
      else if (pv && (!legal(pl[5:3], l[5:3]) || !legal(pl[2:0], l[2:0]))) c = 3;
      else if (pv && ((pl[5:3] == 3'b010 && l[5:3] == 3'b001 && ycnt(1) < my[k]) ||
                      (pl[2:0] == 3'b010 && l[2:0] == 3'b001 && ycnt(0) < my[k]))) c = 4;
      else if (arcnt(ma[k]) < ma[k] && ((l[5:3] == 3'b100 && !(pv && pl[5:3] == 3'b100)) ||
                                        (l[2:0] == 3'b100 && !(pv && pl[2:0] == 3'b100)))) c = 5;
      mp[k] = !mf[k] && c != 0;
      if (mp[k]) begin mf[k] = 1; mc[k] = 3'(c); end
      if (pv && !f && pl[2:0] == 3'b010 && l[2:0] == 3'b001 && mcy[k] < cmax[k]) mcy[k]++;
    end
    s.l = l; s.f = f;
    hist.push_back(s);
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    model_reset();
    #1 reset = 0;
  endtask

  task automatic step(input logic [5:0] l, input logic f);
    {NSG, NSY, NSR, EWG, EWY, EWR} = l;
    flash = f;
    @(posedge clk);
    model_step(l, f);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    {NSG, NSY, NSR, EWG, EWY, EWR} = 6'b100100;
    @(posedge clk);
    model_reset();
    #1;
    checks++;
    if ({f1, c1, p1, ff1, cy1, f2, c2, p2, ff2, cy2} !== '0) begin
      errors++;
      $display("FAIL reset: got f1=%b c1=%0d p1=%b cy1=%0d f2=%b c2=%0d cy2=%0d want all zero", f1, c1, p1, cy1, f2, c2, cy2);
    end
    reset = 0;
  endtask

  task automatic test_normal();
    logic [5:0] s[7] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 7; i++) begin
        step(s[i], 0);
        checks++;
        if ({f1, c1, p1, ff1, cy1} !== {mf[0], mc[0], mp[0], mf[0], 8'(mcy[0])} ||
            {f2, c2, p2, ff2, cy2} !== {mf[1], mc[1], mp[1], mf[1], 3'(mcy[1])}) begin
          errors++;
          $display("FAIL normal r%0d i%0d: got %b/%0d/%b/%0d %b/%0d/%b/%0d want %b/%0d/%b/%0d %b/%0d/%b/%0d", r, i,
                   f1, c1, p1, cy1, f2, c2, p2, cy2, mf[0], mc[0], mp[0], mcy[0], mf[1], mc[1], mp[1], mcy[1]);
        end
      end
    checks++;
    if (f1 !== 1'b0 || cy1 !== 8'd2) begin
      errors++;
      $display("FAIL normal_end: got fault=%b cycles=%0d want fault=0 cycles=2", f1, cy1);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    step(6'b100100, 0);
    checks++;
    if ({f1, c1, p1, ff1} !== {1'b1, 3'd1, 1'b1, 1'b1} || {f2, c2, p2} !== {mf[1], mc[1], mp[1]}) begin
      errors++;
      $display("FAIL conflict: got f=%b c=%0d p=%b ff=%b dut2 c=%0d want f=1 c=1 p=1 ff=1 dut2 c=%0d", f1, c1, p1, ff1, c2, mc[1]);
    end
    step(6'b001001, 0);
    checks++;
    if ({f1, c1, p1, ff1} !== {1'b1, 3'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL conflict_pulse: got f=%b c=%0d p=%b want f=1 c=1 p=0", f1, c1, p1);
    end
  endtask

  task automatic test_sequence();
    logic [5:0] s[3] = '{6'b001001, 6'b100001, 6'b001001};
    do_reset();
    for (int i = 0; i < 3; i++) step(s[i], 0);
    checks++;
    if (c1 !== 3'd3 || c2 !== mc[1] || f1 !== 1'b1) begin
      errors++;
      $display("FAIL sequence: got c1=%0d c2=%0d f1=%b want c1=3 c2=%0d f1=1", c1, c2, f1, mc[1]);
    end
  endtask

  task automatic test_short_yellow();
    logic [5:0] a[4] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001};
    logic [5:0] b[5] = '{6'b001001, 6'b100001, 6'b010001, 6'b010001, 6'b001001};
    do_reset();
    for (int i = 0; i < 4; i++) step(a[i], 0);
    checks++;
    if (c2 !== 3'd4 || f1 !== 1'b0 || c2 !== mc[1]) begin
      errors++;
      $display("FAIL short_y_one: got c2=%0d f1=%b want c2=4 f1=0", c2, f1);
    end
    do_reset();
    for (int i = 0; i < 5; i++) step(b[i], 0);
    checks++;
    if (f2 !== 1'b0 || f1 !== 1'b0 || f2 !== mf[1]) begin
      errors++;
      $display("FAIL short_y_two: got f2=%b c2=%0d f1=%b want no fault", f2, c2, f1);
    end
  endtask

  task automatic test_flash();
    logic [5:0] s[4] = '{6'b001001, 6'b000000, 6'b001001, 6'b000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(s[i], 1);
      checks++;
      if (f1 !== 1'b0 || f2 !== 1'b0) begin
        errors++;
        $display("FAIL flash_alt i%0d: got f1=%b c1=%0d f2=%b want no fault", i, f1, c1, f2);
      end
    end
    step(6'b000000, 1);
    checks++;
    if (c1 !== 3'd6 || c2 !== 3'd6 || p1 !== 1'b1) begin
      errors++;
      $display("FAIL flash_repeat: got c1=%0d c2=%0d p1=%b want 6 6 1", c1, c2, p1);
    end
  endtask

  task automatic test_flash_exit();
    do_reset();
    step(6'b001001, 1);
    step(6'b100001, 0);
    checks++;
    if (c1 !== 3'd5 || c2 !== 3'd5) begin
      errors++;
      $display("FAIL flash_exit_green: got c1=%0d c2=%0d want 5 5", c1, c2);
    end
    do_reset();
    step(6'b000000, 1);
    step(6'b001001, 0);
    step(6'b100001, 0);
    checks++;
    if (f1 !== 1'b0 || c2 !== 3'd5 || c2 !== mc[1]) begin
      errors++;
      $display("FAIL flash_exit_clear: got f1=%b c2=%0d want f1=0 c2=5", f1, c2);
    end
  endtask

  task automatic test_sticky_reset();
    logic [5:0] s[7] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
    do_reset();
    step(6'b011001, 0);
    step(6'b100100, 0);
    step(6'b000000, 1);
    checks++;
    if ({f1, c1, p1, ff1} !== {1'b1, 3'd2, 1'b0, 1'b1} || {f2, c2} !== {mf[1], mc[1]}) begin
      errors++;
      $display("FAIL sticky: got f=%b c=%0d p=%b ff=%b c2=%0d want f=1 c=2 p=0 ff=1 c2=%0d", f1, c1, p1, ff1, c2, mc[1]);
    end
    do_reset();
    checks++;
    if ({f1, c1, p1, ff1, cy1} !== '0) begin
      errors++;
      $display("FAIL sticky_reset: got f=%b c=%0d cy=%0d want zeros", f1, c1, cy1);
    end
    for (int i = 0; i < 7; i++) begin
      step(s[i], 0);
      checks++;
      if ({f1, c1, cy1} !== {mf[0], mc[0], 8'(mcy[0])} || f1 !== 1'b0 || {f2, c2, p2, cy2} !== {mf[1], mc[1], mp[1], 3'(mcy[1])}) begin
        errors++;
        $display("FAIL post_reset i%0d: got f1=%b c1=%0d cy1=%0d f2=%b c2=%0d want f1=0 c2=%0d", i, f1, c1, cy1, f2, c2, mc[1]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [5:0] s[6] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010};
    do_reset();
    for (int r = 0; r < 9; r++)
      for (int i = 0; i < 6; i++) step(s[i], 0);
    step(6'b001001, 0);
    checks++;
    if (cy1 !== 8'd9 || cy2 !== 3'd7 || cy2 !== 3'(mcy[1])) begin
      errors++;
      $display("FAIL saturation: got cy1=%0d cy2=%0d want 9 7", cy1, cy2);
    end
  endtask

  task automatic test_random();
    logic [5:0] leg[6] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010};
    logic [5:0] l;
    bit fm = 0, ph = 0;
    int idx = 0, r;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
        idx = 0;
        fm = 0;
      end else begin
        if (r < 8) fm = !fm;
        if (fm) begin
          if (!(r >= 15 && r < 20)) ph = !ph;
          l = r < 15 ? 6'($urandom) : (ph ? 6'b001001 : 6'b000000);
        end else if (r < 15) l = 6'($urandom);
        else begin
          if ($urandom_range(0, 2) != 0) idx = (idx + 1) % 6;
          l = leg[idx];
        end
        step(l, fm);
      end
      checks++;
      if ({f1, c1, p1, ff1, cy1} !== {mf[0], mc[0], mp[0], mf[0], 8'(mcy[0])} ||
          {f2, c2, p2, ff2, cy2} !== {mf[1], mc[1], mp[1], mf[1], 3'(mcy[1])}) begin
        errors++;
        $display("FAIL random n%0d: got %b/%0d/%b/%0d %b/%0d/%b/%0d want %b/%0d/%b/%0d %b/%0d/%b/%0d", n,
                 f1, c1, p1, cy1, f2, c2, p2, cy2, mf[0], mc[0], mp[0], mcy[0], mf[1], mc[1], mp[1], mcy[1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal();
    test_conflict();
    test_sequence();
    test_short_yellow();
    test_flash();
    test_flash_exit();
    test_sticky_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
